// File: rtl/prog_delay_line.sv
// Programmable 1..MAX_DLY cycle delay for a data word and its write strobe,
// with flush, safe delay reload (busy while refilling) and illegal-load error.
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   iv_data, i_data_wr    input word and strobe
//   iv_dly, i_dly_load    requested delay and single-cycle load request
//   i_flush               discard everything in flight
//   ov_data, o_data_wr    delayed word and strobe
//   ov_dly_cur            delay currently in force
//   o_dly_busy            pipeline refilling after a reload
//   o_dly_err             one-cycle pulse on a rejected load
module prog_delay_line #(
  parameter int DW          = 8,
  parameter int MAX_DLY     = 16,
  parameter int DLY_W       = 5,
  parameter int DEFAULT_DLY = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DW-1:0]    iv_data,
  input  logic             i_data_wr,
  input  logic [DLY_W-1:0] iv_dly,
  input  logic             i_dly_load,
  input  logic             i_flush,
  output logic [DW-1:0]    ov_data,
  output logic             o_data_wr,
  output logic [DLY_W-1:0] ov_dly_cur,
  output logic             o_dly_busy,
  output logic             o_dly_err
);

  // Each stage holds {wr, data}.
  logic [DW:0]      stg [MAX_DLY];
  logic [DLY_W-1:0] cur;
  logic [DLY_W-1:0] cnt;
  logic             err;
  logic             in_range;
  logic             legal;
  logic             clr;
  logic [DW:0]      tap;

  assign in_range = (iv_dly != '0) &&
                    (iv_dly <= DLY_W'(MAX_DLY));
  assign legal    = i_dly_load & in_range;
  // A legal load is a superset of a flush.
  assign clr      = legal | i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < MAX_DLY; i++)
        stg[i] <= '0;
      cur <= DLY_W'(DEFAULT_DLY);
      cnt <= '0;
      err <= 1'b0;
    end else begin
      err <= i_dly_load & ~in_range;
      if (clr) begin
        for (int i = 0; i < MAX_DLY; i++)
          stg[i] <= '0;
      end else begin
        stg[0] <= {i_data_wr, iv_data};
        for (int i = 1; i < MAX_DLY; i++)
          stg[i] <= stg[i-1];
      end
      // Busy spans exactly D_new cycles: the first new word
      // reaches the tap just as cnt returns to zero.
      if (legal) begin
        cur <= iv_dly;
        cnt <= iv_dly;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Tap select: stage D-1 is already a register, so no
  // input-to-output combinational path exists.
  always_comb begin
    tap = '0;
    for (int i = 0; i < MAX_DLY; i++)
      if (cur == DLY_W'(i + 1))
        tap = stg[i];
  end

  assign ov_data    = tap[DW-1:0];
  assign o_dly_busy = (cnt != '0);
  assign o_data_wr  = tap[DW] & ~o_dly_busy;
  assign ov_dly_cur = cur;
  assign o_dly_err  = err;

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed, table-driven bench for prog_delay_line.
// Each vector: inputs before an edge, expected outputs just after it.
module tb_prog_delay_line;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       wr;
  logic [4:0] dly;
  logic       ld;
  logic       fl;
  logic [7:0] o_data;
  logic       o_wr;
  logic [4:0] o_cur;
  logic       o_busy;
  logic       o_err;

  int checks = 0;
  int errors = 0;

  prog_delay_line #(
    .DW(8), .MAX_DLY(16), .DLY_W(5), .DEFAULT_DLY(2)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .iv_data(data),
    .i_data_wr(wr),
    .iv_dly(dly),
    .i_dly_load(ld),
    .i_flush(fl),
    .ov_data(o_data),
    .o_data_wr(o_wr),
    .ov_dly_cur(o_cur),
    .o_dly_busy(o_busy),
    .o_dly_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       wr;
    logic [4:0] dly;
    logic       ld;
    logic       fl;
    logic [7:0] ed;
    logic       ewr;
    logic [4:0] ecur;
    logic       ebusy;
    logic       eerr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] d, input logic w,
                     input logic [4:0] dl, input logic l,
                     input logic f, input logic [7:0] ed,
                     input logic ew, input logic [4:0] ec,
                     input logic eb, input logic ee);
    vec_t v;
    v.d = d; v.wr = w; v.dly = dl; v.ld = l; v.fl = f;
    v.ed = ed; v.ewr = ew; v.ecur = ec;
    v.ebusy = eb; v.eerr = ee;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [7:0] ed,
                       input logic ew, input logic [4:0] ec,
                       input logic eb, input logic ee);
    checks++;
    if ({o_data, o_wr, o_cur, o_busy, o_err} !==
        {ed, ew, ec, eb, ee}) begin
      errors++;
      $display("FAIL %s got data=%h wr=%b cur=%0d busy=%b err=%b want data=%h wr=%b cur=%0d busy=%b err=%b",
               nm, o_data, o_wr, o_cur, o_busy, o_err,
               ed, ew, ec, eb, ee);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic w,
                       input logic [4:0] dl, input logic l,
                       input logic f);
    @(negedge clk);
    data = d; wr = w; dly = dl; ld = l; fl = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    data = '0; wr = 0; dly = '0; ld = 0; fl = 0;

    // A: default delay 2, 15 back-to-back strobes
    for (int i = 0; i < 17; i++)
      add((i < 15) ? 8'(8'h11 + i) : 8'h00, i < 15,
          5'd0, 0, 0,
          (i >= 1 && i <= 15) ? 8'(8'h10 + i) : 8'h00,
          i >= 1 && i <= 15, 5'd2, 0, 0);
    // B: reload 2->7 with strobes in flight
    add(8'h30, 1, 5'd0, 0, 0, 8'h00, 0, 5'd2, 0, 0);
    add(8'h31, 1, 5'd0, 0, 0, 8'h30, 1, 5'd2, 0, 0);
    add(8'h32, 1, 5'd7, 1, 0, 8'h00, 0, 5'd7, 1, 0);
    add(8'hA5, 1, 5'd0, 0, 0, 8'h00, 0, 5'd7, 1, 0);
    for (int m = 2; m <= 8; m++)
      add(8'h00, 0, 5'd0, 0, 0,
          (m == 7) ? 8'hA5 : 8'h00, m == 7,
          5'd7, m <= 6, 0);
    // C: delay 1, data passes without strobe too
    add(8'h00, 0, 5'd1, 1, 0, 8'h00, 0, 5'd1, 1, 0);
    add(8'h42, 1, 5'd0, 0, 0, 8'h42, 1, 5'd1, 0, 0);
    add(8'h43, 0, 5'd0, 0, 0, 8'h43, 0, 5'd1, 0, 0);
    add(8'h44, 1, 5'd0, 0, 0, 8'h44, 1, 5'd1, 0, 0);
    // D: illegal loads 0 and 17, stream continues
    add(8'h50, 1, 5'd0, 1, 0, 8'h50, 1, 5'd1, 0, 1);
    add(8'h51, 1, 5'd0, 0, 0, 8'h51, 1, 5'd1, 0, 0);
    add(8'h52, 1, 5'd17, 1, 0, 8'h52, 1, 5'd1, 0, 1);
    add(8'h53, 1, 5'd0, 0, 0, 8'h53, 1, 5'd1, 0, 0);
    add(8'h00, 0, 5'd0, 0, 0, 8'h00, 0, 5'd1, 0, 0);
    // E: maximum delay 16
    add(8'h00, 0, 5'd16, 1, 0, 8'h00, 0, 5'd16, 1, 0);
    for (int m = 1; m <= 18; m++)
      add((m == 1) ? 8'h61 : (m == 2) ? 8'h62 : 8'h00,
          m <= 2, 5'd0, 0, 0,
          (m == 16) ? 8'h61 : (m == 17) ? 8'h62 : 8'h00,
          m == 16 || m == 17, 5'd16, m <= 15, 0);
    // F: flush at D=5 with 4 strobes in flight
    add(8'h00, 0, 5'd5, 1, 0, 8'h00, 0, 5'd5, 1, 0);
    for (int m = 1; m <= 4; m++)
      add(8'(8'h70 + m), 1, 5'd0, 0, 0,
          8'h00, 0, 5'd5, 1, 0);
    add(8'h75, 1, 5'd0, 0, 1, 8'h00, 0, 5'd5, 0, 0);
    add(8'h76, 1, 5'd0, 0, 0, 8'h00, 0, 5'd5, 0, 0);
    for (int m = 7; m <= 11; m++)
      add(8'h00, 0, 5'd0, 0, 0,
          (m == 10) ? 8'h76 : 8'h00, m == 10,
          5'd5, 0, 0);
    // G: flush+load 3, then load 9 while busy
    add(8'h81, 1, 5'd3, 1, 1, 8'h00, 0, 5'd3, 1, 0);
    add(8'h82, 1, 5'd0, 0, 0, 8'h00, 0, 5'd3, 1, 0);
    add(8'h00, 0, 5'd9, 1, 0, 8'h00, 0, 5'd9, 1, 0);
    add(8'h90, 1, 5'd0, 0, 0, 8'h00, 0, 5'd9, 1, 0);
    for (int m = 4; m <= 12; m++)
      add(8'h00, 0, 5'd0, 0, 0,
          (m == 11) ? 8'h90 : 8'h00, m == 11,
          5'd9, m <= 10, 0);

    // Reset state
    @(posedge clk);
    #1;
    check("reset", 8'h00, 0, 5'd2, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].d, tbl[i].wr, tbl[i].dly,
            tbl[i].ld, tbl[i].fl);
      check($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ewr,
            tbl[i].ecur, tbl[i].ebusy, tbl[i].eerr);
    end

    // H: reset mid-stream at D=8 with alternating strobes
    drive(8'h00, 0, 5'd8, 1, 0);
    check("h_load8", 8'h00, 0, 5'd8, 1, 0);
    for (int m = 1; m <= 10; m++) begin
      drive(8'(8'hC0 + m - 1), 1'((m - 1) % 2),
            5'd0, 0, 0);
      if (m >= 8)
        check($sformatf("h_stream%0d", m),
              8'(8'hC0 + m - 8), 1'((m - 8) % 2),
              5'd8, 0, 0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("h_rst_async", 8'h00, 0, 5'd2, 0, 0);
    @(negedge clk);
    data = '0; wr = 0;
    @(posedge clk);
    #1;
    check("h_rst_hold", 8'h00, 0, 5'd2, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'hD1, 1, 5'd0, 0, 0);
    check("h_post0", 8'h00, 0, 5'd2, 0, 0);
    drive(8'h00, 0, 5'd0, 0, 0);
    check("h_post1", 8'hD1, 1, 5'd2, 0, 0);
    drive(8'h00, 0, 5'd0, 0, 0);
    check("h_post2", 8'h00, 0, 5'd2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_delay_line.md
Name: prog_delay_line

Overview:
- Parametrised successor of the fixed two-stage data/strobe delay.
- Delays a DW-bit data word and its write strobe by a runtime-programmable number of clock cycles, 1..MAX_DLY.
- Adds in-flight flush, safe delay reload with a settling indication, and illegal-value rejection.
- Used to align datapaths of differing latency, e.g. sideband strobes against pipelined processing.

Parameters:
- DW, 8, data width in bits.
- MAX_DLY, 16, maximum delay in cycles (>=2); sets the shift-register depth.
- DLY_W, 5, width of the delay-select port; must satisfy 2^DLY_W > MAX_DLY.
- DEFAULT_DLY, 2, delay in force after reset (1..MAX_DLY); 2 reproduces the legacy block.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- iv_data  in  DW  input data word.
- i_data_wr  in  1  input write strobe.
- iv_dly  in  DLY_W  requested delay; sampled only when i_dly_load=1.
- i_dly_load  in  1  single-cycle request to apply iv_dly.
- i_flush  in  1  discard all in-flight data and strobes.
- ov_data  out  DW  delayed data.
- o_data_wr  out  1  delayed strobe.
- ov_dly_cur  out  DLY_W  delay currently in force.
- o_dly_busy  out  1  high while the pipeline refills after a reload.
- o_dly_err  out  1  one-cycle pulse when a load request is rejected.

Behaviour:
- Reset (async assert, sync release):
  - All MAX_DLY stages of {wr,data} cleared.
  - ov_data=0, o_data_wr=0, ov_dly_cur=DEFAULT_DLY, o_dly_busy=0, o_dly_err=0.
- Structure:
  - MAX_DLY-stage shift register of {i_data_wr, iv_data}, shifting every cycle.
  - Outputs are taken from stage D-1 (D = ov_dly_cur), so the output is stage-registered with no combinational input-to-output path.
- Latency:
  - A word presented before edge k appears on ov_data/o_data_wr after edge k+D-1, i.e. visible for exactly D cycles later, one cycle wide per input cycle.
  - Data passes regardless of the strobe; back-to-back strobes are preserved with no bubbles.
- Load, legal (1<=iv_dly<=MAX_DLY):
  - At the load edge, ov_dly_cur<=iv_dly and all stages' wr bits are cleared. This discards strobes in flight, including the one presented in the load cycle.
  - Data bits are cleared as well, so ov_data=0 until new data arrives.
  - o_dly_busy goes high on the load edge and stays high for exactly D_new cycles, counted by an internal down-counter.
  - While busy, o_data_wr is forced 0.
  - Inputs presented in the cycle after the load edge emerge exactly when busy deasserts.
- Load, illegal (iv_dly=0 or >MAX_DLY):
  - No state change: ov_dly_cur and the pipeline are untouched.
  - o_dly_err pulses 1 for one cycle.
- Load with iv_dly equal to ov_dly_cur: treated as a legal load, so it flushes and sets busy.
- Flush (i_flush=1):
  - All stages cleared at that edge, including the current input; ov_dly_cur is unchanged and busy is not set.
  - Outputs read 0 from the next cycle until post-flush data reaches stage D-1.
- Simultaneous events:
  - i_flush and a legal i_dly_load: load behaviour applies (it is a superset).
  - i_flush and an illegal load: flush applies and o_dly_err pulses.
  - A load while busy: the counter restarts from the new D.
- Reset mid-operation: immediate return to reset values, discarding the pipeline and busy state.

Test Plan:
- Default delay: after reset, drive iv_data=0x11..0x1F with i_data_wr=1 for 15 consecutive cycles -> identical sequence on ov_data with o_data_wr=1, lagging exactly 2 cycles; ov_dly_cur=2.
- Reload 2->7:
  - Pulse i_dly_load with iv_dly=7 while strobes are in flight -> in-flight strobes dropped, o_dly_busy high for 7 cycles, o_data_wr=0 throughout.
  - Then 0xA5 presented in the cycle after the load appears exactly 7 cycles later.
- Boundaries:
  - iv_dly=1 -> 1-cycle latency.
  - iv_dly=16 -> 16-cycle latency.
  - iv_dly=0 and iv_dly=17 -> o_dly_err one-cycle pulse, ov_dly_cur unchanged, data stream uninterrupted.
- Flush at D=5 with 4 strobes in flight -> none of them emerge, ov_data=0. A strobe presented the cycle after the flush emerges 5 cycles later, with o_dly_busy staying 0.
- Flush and load 3 in the same cycle -> load semantics: busy for 3 cycles, ov_dly_cur=3. A load of 9 issued while busy -> busy restarts for 9 cycles.
- Reset mid-stream at D=8 with alternating strobes -> all outputs 0 immediately, ov_dly_cur=2 after release, the first post-reset word emerges 2 cycles later.
